// File: rtl/ddr3_native_pkg.sv
// Shared definitions for the DDR3 native-port arbiter: MIG command codes, address step and the
// arbiter state encoding.
package ddr3_native_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int unsigned ADDR_STEP = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWrXfer = 2'd1,
    StRdXfer = 2'd2,
    StDone   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ddr3_native_arbiter.sv
// Round-robin write/read burst arbiter between the DMA FIFO controller and the MIG native app port.
// One shared command-issue counter block serves both directions.
module ddr3_native_arbiter
  import ddr3_native_pkg::*;
#(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BL_W      = 8,
  parameter int unsigned ADDR_STEP = ddr3_native_pkg::ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              wr_data_req,
  input  logic              rd_data_req,
  output logic              wr_cmd_rden,
  input  logic [2:0]        wr_cmd_rdcmd,
  input  logic [BL_W-1:0]   wr_cmd_rdbl,
  input  logic [ADDR_W-1:0] wr_cmd_rdaddr,
  output logic              wr_fifo_rden,
  input  logic [DATA_W-1:0] wr_fifo_rdata,
  output logic              rd_cmd_rden,
  input  logic [2:0]        rd_cmd_rdcmd,
  input  logic [BL_W-1:0]   rd_cmd_rdbl,
  input  logic [ADDR_W-1:0] rd_cmd_rdaddr,
  output logic              rd_fifo_wren,
  output logic [DATA_W-1:0] rd_fifo_wdata,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam logic [ADDR_W-1:0] AddrInc = ADDR_W'(ADDR_STEP);

  arb_state_e        state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [BL_W-1:0]   bl_q, bl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W:0]     cmd_cnt_q, cmd_cnt_d;
  logic [BL_W:0]     dat_cnt_q, dat_cnt_d;
  logic              wr_rden_q, wr_rden_d;
  logic              rd_rden_q, rd_rden_d;
  logic              burst_rd_q, burst_rd_d;
  logic              last_rd_q, last_rd_d;

  logic [BL_W:0] bl_ext, cmd_cnt_nxt, dat_cnt_nxt;
  logic          in_xfer, issue, cmd_fire, wr_beat, rd_beat, xfer_done, grant_wr, grant_rd;

  assign bl_ext      = {1'b0, bl_q};
  assign in_xfer     = (state_q == StWrXfer) || (state_q == StRdXfer);
  assign issue       = in_xfer && (cmd_cnt_q < bl_ext);
  assign cmd_fire    = issue && app_rdy;
  assign wr_beat     = (state_q == StWrXfer) && (dat_cnt_q < bl_ext) && app_wdf_rdy;
  assign rd_beat     = (state_q == StRdXfer) && (dat_cnt_q < bl_ext) && app_rd_data_valid;
  assign cmd_cnt_nxt = cmd_cnt_q + {{BL_W{1'b0}}, cmd_fire};
  assign dat_cnt_nxt = dat_cnt_q + {{BL_W{1'b0}}, (wr_beat | rd_beat)};
  // Completion counts this cycle's final command/beat so the exit is not delayed a cycle.
  assign xfer_done   = (cmd_cnt_nxt == bl_ext) && (dat_cnt_nxt == bl_ext);

  // Write wins unless it had the previous grant and a read is waiting.
  assign grant_wr = init_calib_complete && wr_data_req && (last_rd_q || !rd_data_req);
  assign grant_rd = init_calib_complete && rd_data_req && !grant_wr;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    bl_d       = bl_q;
    addr_d     = addr_q;
    cmd_cnt_d  = cmd_cnt_q;
    dat_cnt_d  = dat_cnt_q;
    wr_rden_d  = wr_rden_q;
    rd_rden_d  = rd_rden_q;
    burst_rd_d = burst_rd_q;
    last_rd_d  = last_rd_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          cmd_d      = wr_cmd_rdcmd;
          bl_d       = wr_cmd_rdbl;
          addr_d     = wr_cmd_rdaddr;
          cmd_cnt_d  = '0;
          dat_cnt_d  = '0;
          wr_rden_d  = 1'b1;
          burst_rd_d = 1'b0;
          state_d    = StWrXfer;
        end else if (grant_rd) begin
          cmd_d      = rd_cmd_rdcmd;
          bl_d       = rd_cmd_rdbl;
          addr_d     = rd_cmd_rdaddr;
          cmd_cnt_d  = '0;
          dat_cnt_d  = '0;
          rd_rden_d  = 1'b1;
          burst_rd_d = 1'b1;
          state_d    = StRdXfer;
        end
      end
      StWrXfer, StRdXfer: begin
        cmd_cnt_d = cmd_cnt_nxt;
        dat_cnt_d = dat_cnt_nxt;
        if (cmd_fire) begin
          addr_d = addr_q + AddrInc;
        end
        if (xfer_done) begin
          wr_rden_d = 1'b0;
          rd_rden_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        last_rd_d = burst_rd_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      bl_q       <= '0;
      addr_q     <= '0;
      cmd_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      wr_rden_q  <= 1'b0;
      rd_rden_q  <= 1'b0;
      burst_rd_q <= 1'b0;
      last_rd_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      bl_q       <= bl_d;
      addr_q     <= addr_d;
      cmd_cnt_q  <= cmd_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      wr_rden_q  <= wr_rden_d;
      rd_rden_q  <= rd_rden_d;
      burst_rd_q <= burst_rd_d;
      last_rd_q  <= last_rd_d;
    end
  end

  assign wr_cmd_rden   = wr_rden_q;
  assign rd_cmd_rden   = rd_rden_q;
  assign app_en        = issue;
  assign app_addr      = addr_q;
  assign app_cmd       = cmd_q;
  assign wr_fifo_rden  = wr_beat;
  assign app_wdf_wren  = wr_beat;
  assign app_wdf_end   = wr_beat;
  assign app_wdf_data  = wr_fifo_rdata;
  assign rd_fifo_wren  = app_rd_data_valid;
  assign rd_fifo_wdata = app_rd_data;

endmodule

// File: tb/tb_ddr3_native_arbiter.sv
// Directed bench for ddr3_native_arbiter: a table of single bursts plus hand-written sequences for
// calibration gating, round-robin alternation and reset in the middle of a burst.
module tb_ddr3_native_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned BL_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init_calib_complete;
  logic              wr_data_req, rd_data_req;
  logic              wr_cmd_rden, rd_cmd_rden;
  logic [2:0]        wr_cmd_rdcmd, rd_cmd_rdcmd;
  logic [BL_W-1:0]   wr_cmd_rdbl, rd_cmd_rdbl;
  logic [ADDR_W-1:0] wr_cmd_rdaddr, rd_cmd_rdaddr;
  logic              wr_fifo_rden, rd_fifo_wren;
  logic [DATA_W-1:0] wr_fifo_rdata, rd_fifo_wdata;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_rdy;
  logic [DATA_W-1:0] app_wdf_data, app_rd_data;
  logic              app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;

  always #5 clk = ~clk;

  ddr3_native_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .wr_data_req         (wr_data_req),
    .rd_data_req         (rd_data_req),
    .wr_cmd_rden         (wr_cmd_rden),
    .wr_cmd_rdcmd        (wr_cmd_rdcmd),
    .wr_cmd_rdbl         (wr_cmd_rdbl),
    .wr_cmd_rdaddr       (wr_cmd_rdaddr),
    .wr_fifo_rden        (wr_fifo_rden),
    .wr_fifo_rdata       (wr_fifo_rdata),
    .rd_cmd_rden         (rd_cmd_rden),
    .rd_cmd_rdcmd        (rd_cmd_rdcmd),
    .rd_cmd_rdbl         (rd_cmd_rdbl),
    .rd_cmd_rdaddr       (rd_cmd_rdaddr),
    .rd_fifo_wren        (rd_fifo_wren),
    .rd_fifo_wdata       (rd_fifo_wdata),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid)
  );

  typedef struct {
    bit               wr;
    logic [BL_W-1:0]  bl;
    logic [ADDR_W-1:0] addr;
    bit               stall;
    int               exp_n;
    logic [ADDR_W-1:0] exp_end;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit cur_wr, prev_active, done_flag, armed, stall, drop_req;
  int ncmd, nbeat, nrd, wr_ptr, ret_idx, rise_cyc, fall_cyc, last_act, low_run, nbursts;
  logic [ADDR_W-1:0] exp_addr, tb_wr_addr, tb_rd_addr;
  bit grants[$];
  int rdq[$];

  function automatic logic [DATA_W-1:0] wpat(input int i);
    return {8{32'hC0DE_0000 ^ 32'(i)}};
  endfunction

  function automatic logic [DATA_W-1:0] rpat(input int i);
    return {8{32'h5EED_0000 + 32'(i)}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs from the MIG and FIFO models, applied just after the clock edge.
  task automatic drive();
    int age;
    age = cyc - rise_cyc;
    app_rdy     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    app_wdf_rdy = (stall && (armed || age < 10)) ? 1'b0 : 1'b1;
    wr_fifo_rdata = wpat(wr_ptr);
    if (rdq.size() > 0 && cyc >= rdq[0] + 20 && (!stall || $urandom_range(0, 2) != 0)) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = rpat(ret_idx);
      ret_idx++;
      void'(rdq.pop_front());
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
    end
    if (drop_req && !armed) begin
      wr_data_req = 1'b0;
      rd_data_req = 1'b0;
    end
  endtask

  // Observes one cycle just before the clock edge.
  task automatic sample();
    logic active;
    cyc++;
    active = wr_cmd_rden | rd_cmd_rden;
    chk("rden_exclusive", {wr_cmd_rden, rd_cmd_rden} == 2'b11, 1'b0);
    if (active && !prev_active) begin
      cur_wr = wr_cmd_rden;
      grants.push_back(wr_cmd_rden);
      if (nbursts > 0) chk("rden_low_gap", low_run >= 2, 1'b1);
      nbursts++;
      exp_addr = wr_cmd_rden ? tb_wr_addr : tb_rd_addr;
      ncmd = 0; nbeat = 0; nrd = 0; ret_idx = 0;
      rise_cyc = cyc; last_act = cyc; armed = 1'b0;
    end
    if (!active && prev_active) begin
      fall_cyc = cyc; done_flag = 1'b1; wr_ptr = 0;
    end
    low_run = active ? 0 : low_run + 1;
    prev_active = active;
    if (app_en) begin
      chk("app_en_in_burst", active, 1'b1);
      chk("app_addr_seq", app_addr, exp_addr);
      chk("app_cmd", app_cmd, cur_wr ? 3'b000 : 3'b001);
      if (app_rdy) begin
        ncmd++;
        exp_addr = exp_addr + 28'd8;
        last_act = cyc;
        if (!cur_wr) rdq.push_back(cyc);
      end
    end
    chk("wdf_ctl", {app_wdf_end, wr_fifo_rden}, {app_wdf_wren, app_wdf_wren});
    if (app_wdf_wren) begin
      checks++;
      if (app_wdf_data !== wpat(nbeat)) begin
        errors++;
        $display("FAIL wdf_data beat %0d: got %h, expected %h", nbeat, app_wdf_data, wpat(nbeat));
      end
      nbeat++; wr_ptr++; last_act = cyc;
    end
    chk("rd_wren_pass", rd_fifo_wren, app_rd_data_valid);
    if (rd_fifo_wren) begin
      checks++;
      if (rd_fifo_wdata !== rpat(nrd)) begin
        errors++;
        $display("FAIL rd_data beat %0d: got %h, expected %h", nrd, rd_fifo_wdata, rpat(nrd));
      end
      nrd++;
      if (active) last_act = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    #7 sample();
  endtask

  task automatic run_burst(input vec_t v);
    stall = v.stall; armed = 1'b1; drop_req = 1'b1; done_flag = 1'b0; wr_ptr = 0;
    if (v.wr) begin
      tb_wr_addr = v.addr; wr_cmd_rdaddr = v.addr; wr_cmd_rdbl = v.bl; wr_data_req = 1'b1;
    end else begin
      tb_rd_addr = v.addr; rd_cmd_rdaddr = v.addr; rd_cmd_rdbl = v.bl; rd_data_req = 1'b1;
    end
    for (int i = 0; i < 4000 && !done_flag; i++) step();
    chk("burst_done", done_flag, 1'b1);
    repeat (2) step();
    chk("burst_dir", cur_wr, v.wr);
    chk("cmd_count", ncmd, v.exp_n);
    chk("beat_count", v.wr ? nbeat : nrd, v.exp_n);
    chk("exit_latency", fall_cyc - last_act, 1);
    chk("end_addr", app_addr, v.exp_end);
  endtask

  initial begin
    vecs[0] = '{wr: 1, bl: 8'd64,  addr: 28'h200,     stall: 0, exp_n: 64,  exp_end: 28'h400};
    vecs[1] = '{wr: 1, bl: 8'd64,  addr: 28'h200,     stall: 1, exp_n: 64,  exp_end: 28'h400};
    vecs[2] = '{wr: 0, bl: 8'd64,  addr: 28'h1000,    stall: 1, exp_n: 64,  exp_end: 28'h1200};
    vecs[3] = '{wr: 1, bl: 8'd0,   addr: 28'h300,     stall: 0, exp_n: 0,   exp_end: 28'h300};
    vecs[4] = '{wr: 1, bl: 8'd2,   addr: 28'hFFFFFF8, stall: 0, exp_n: 2,   exp_end: 28'h0000008};
    vecs[5] = '{wr: 0, bl: 8'd255, addr: 28'h20,      stall: 0, exp_n: 255, exp_end: 28'h818};
    vecs[6] = '{wr: 0, bl: 8'd1,   addr: 28'h7,       stall: 0, exp_n: 1,   exp_end: 28'hF};

    init_calib_complete = 1'b0;
    wr_data_req = 1'b0; rd_data_req = 1'b0;
    wr_cmd_rdcmd = 3'b000; rd_cmd_rdcmd = 3'b001;
    wr_cmd_rdbl = '0; rd_cmd_rdbl = '0; wr_cmd_rdaddr = '0; rd_cmd_rdaddr = '0;
    wr_fifo_rdata = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    stall = 1'b0; armed = 1'b0; drop_req = 1'b0; prev_active = 1'b0; done_flag = 1'b0;
    ncmd = 0; nbeat = 0; nrd = 0; wr_ptr = 0; ret_idx = 0;
    rise_cyc = 0; fall_cyc = 0; last_act = 0; low_run = 0; nbursts = 0;
    exp_addr = '0; tb_wr_addr = '0; tb_rd_addr = '0; cur_wr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctl", {app_en, wr_cmd_rden, rd_cmd_rden, wr_fifo_rden, app_wdf_wren, app_wdf_end,
                      rd_fifo_wren}, 7'b0);
    chk("reset_addr", app_addr, 28'h0);
    chk("reset_cmd", app_cmd, 3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Calibration incomplete: requests must be ignored
    begin
      bit seen;
      seen = 1'b0;
      wr_data_req = 1'b1; rd_data_req = 1'b1;
      wr_cmd_rdbl = 8'd4; rd_cmd_rdbl = 8'd4;
      for (int i = 0; i < 100; i++) begin
        step();
        if (app_en || wr_cmd_rden || rd_cmd_rden || wr_fifo_rden) seen = 1'b1;
      end
      chk("calib_gate", seen, 1'b0);
      wr_data_req = 1'b0; rd_data_req = 1'b0;
      init_calib_complete = 1'b1;
      step();
    end

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Both requests held: last grant was a read, so the order is W,R,W,R
    grants.delete();
    stall = 1'b0; drop_req = 1'b0;
    tb_wr_addr = 28'h40; tb_rd_addr = 28'h80;
    wr_cmd_rdaddr = 28'h40; rd_cmd_rdaddr = 28'h80;
    wr_cmd_rdbl = 8'd4; rd_cmd_rdbl = 8'd4;
    wr_data_req = 1'b1; rd_data_req = 1'b1;
    for (int i = 0; i < 2000 && grants.size() < 4; i++) step();
    wr_data_req = 1'b0; rd_data_req = 1'b0;
    done_flag = 1'b0;
    for (int i = 0; i < 500 && !done_flag; i++) step();
    chk("rr_done", done_flag, 1'b1);
    chk("rr_count", grants.size(), 4);
    begin
      bit [3:0] order;
      order = '0;
      for (int i = 0; i < 4 && i < grants.size(); i++) order[3-i] = grants[i];
      chk("rr_order", order, 4'b1010);
    end
    repeat (3) step();

    // Reset while a write burst is at beat 30
    stall = 1'b0; armed = 1'b1; drop_req = 1'b1; done_flag = 1'b0; wr_ptr = 0;
    tb_wr_addr = 28'h200; wr_cmd_rdaddr = 28'h200; wr_cmd_rdbl = 8'd64; wr_data_req = 1'b1;
    for (int i = 0; i < 300 && nbeat < 30; i++) step();
    chk("pre_reset_beats", nbeat, 30);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_reset_ctl", {app_en, wr_cmd_rden, rd_cmd_rden, wr_fifo_rden, app_wdf_wren,
                          app_wdf_end}, 6'b0);
    chk("mid_reset_addr", app_addr, 28'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    prev_active = 1'b0; low_run = 10; wr_ptr = 0; rdq.delete(); grants.delete();
    done_flag = 1'b0; armed = 1'b1; drop_req = 1'b1;
    tb_wr_addr = 28'h5000; wr_cmd_rdaddr = 28'h5000; wr_cmd_rdbl = 8'd8;
    tb_rd_addr = 28'h6000; rd_cmd_rdaddr = 28'h6000; rd_cmd_rdbl = 8'd8;
    wr_data_req = 1'b1; rd_data_req = 1'b1;
    for (int i = 0; i < 100 && grants.size() == 0; i++) step();
    chk("post_reset_grant_wr", grants.size() > 0 && grants[0], 1'b1);
    chk("post_reset_addr", app_addr, 28'h5000);
    for (int i = 0; i < 500 && !done_flag; i++) step();
    chk("post_reset_done", done_flag, 1'b1);
    chk("post_reset_beats", nbeat, 8);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
